// File: rtl/snake_io_pkg.sv
// Shared register map and capture-mode encodings for the snake SoC input PIOs.
package snake_io_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_MODE    = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_t;

endpackage

// File: rtl/snake_debounce_bit.sv
// One input channel: 2-flop synchroniser followed by a saturating-free
// debounce counter that commits a new stable level only after the synchronised
// input has disagreed with it for N consecutive cycles.
module snake_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic stable_o
);

  // 0 and 1 both mean "no filtering": commit on the first disagreeing cycle.
  localparam int N  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(N - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreements; any return to the stable level restarts.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TC) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, counter and stable level, all cleared together on reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q  <= RESET_VAL;
      sync2_q  <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/snake_input_pio.sv
// Avalon-MM input PIO: debounced inputs, selectable edge capture and a
// maskable level interrupt. Read latency is one cycle, no waitrequest.
module snake_input_pio
  import snake_io_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_q;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  mode_t            mode_q, mode_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] w1c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    snake_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (RESET_VALUE[i])
    ) u_bit (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .din_i   (gpio_in[i]),
      .stable_o(stable[i])
    );
  end

  // Only the low WIDTH bits of a write are meaningful; the rest is dropped.
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Edge events, register writes and read mux. Reads use pre-write values.
  always_comb begin
    evt = '0;
    if (mode_q == MODE_RISE || mode_q == MODE_BOTH) evt = evt | (stable & ~stable_d_q);
    if (mode_q == MODE_FALL || mode_q == MODE_BOTH) evt = evt | (~stable & stable_d_q);

    w1c = '0;
    if (avs_write && avs_address == ADDR_EDGECAP) w1c = avs_writedata[WIDTH-1:0];
    // A capture landing on the same edge as its clear must survive.
    edgecap_d = (edgecap_q & ~w1c) | evt;

    irqmask_d = irqmask_q;
    if (avs_write && avs_address == ADDR_IRQMASK) irqmask_d = avs_writedata[WIDTH-1:0];

    mode_d = mode_q;
    if (avs_write && avs_address == ADDR_MODE) mode_d = mode_t'(avs_writedata[1:0]);

    readdata_d = readdata_q;
    if (avs_read) begin
      readdata_d = '0;
      case (avs_address)
        ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
        ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
        ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
        ADDR_MODE:    readdata_d[1:0]       = mode_q;
        default:      readdata_d            = '0;
      endcase
    end
  end

  // Register file state.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      stable_d_q <= RESET_VALUE;
      edgecap_q  <= '0;
      irqmask_q  <= '0;
      mode_q     <= MODE_RISE;
      readdata_q <= '0;
    end else begin
      stable_d_q <= stable;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_snake_input_pio.sv
// Bench for snake_input_pio (WIDTH=4, DEBOUNCE_CYCLES=8, RESET_VALUE=4'hF).
module tb_snake_input_pio;

  localparam int         W   = 4;
  localparam int         DEB = 8;
  localparam logic [3:0] RV  = 4'hF;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [3:0]  gpio_in = 4'hF;
  logic        irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  snake_input_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .RESET_VALUE(RV)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .gpio_in(gpio_in), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the stable level flips once the last DEB synchronised
  // samples all disagree with it; capture/irq/register rules applied directly.
  logic [3:0]  g1, g2, m_st, m_std, m_ec, m_mask;
  logic [1:0]  m_mode;
  logic [31:0] m_rd;
  logic [3:0]  hist[$];

  always @(posedge clk_clk) begin
    logic [3:0] s, ev, w, new_ec;
    bit flip;
    if (!reset_reset_n) begin
      g1 = RV; g2 = RV; m_st = RV; m_std = RV;
      m_ec = '0; m_mask = '0; m_mode = 2'b01; m_rd = '0;
      hist = {};
      for (int i = 0; i < DEB; i++) hist.push_back(RV);
    end else begin
      s = g2; g2 = g1; g1 = gpio_in;
      hist.push_back(s);
      if (hist.size() > DEB) void'(hist.pop_front());
      ev = '0;
      if (m_mode[0]) ev = ev | (m_st & ~m_std);
      if (m_mode[1]) ev = ev | (~m_st & m_std);
      if (avs_read) begin
        m_rd = '0;
        case (avs_address)
          2'd0: m_rd[3:0] = m_st;
          2'd1: m_rd[3:0] = m_mask;
          2'd2: m_rd[3:0] = m_ec;
          default: m_rd[1:0] = m_mode;
        endcase
      end
      w = (avs_write && avs_address == 2'd2) ? avs_writedata[3:0] : 4'h0;
      new_ec = (m_ec & ~w) | ev;
      if (avs_write && avs_address == 2'd1) m_mask = avs_writedata[3:0];
      if (avs_write && avs_address == 2'd3) m_mode = avs_writedata[1:0];
      m_std = m_st;
      for (int b = 0; b < 4; b++) begin
        flip = 1'b1;
        foreach (hist[i]) if (hist[i][b] == m_st[b]) flip = 1'b0;
        if (flip) m_st[b] = ~m_st[b];
      end
      m_ec = new_ec;
    end
  end

  always @(negedge clk_clk) begin
    check("model_readdata", avs_readdata, m_rd);
    check("model_irq", {31'd0, irq}, {31'd0, |(m_ec & m_mask)});
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Holds a read of DATA and reports cycles from 'start' until bit b reads 0.
  task automatic wait_data_low(input int b, input int start, input int exp_lat, input string name);
    int got;
    got = -1;
    avs_address = 2'd0; avs_read = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_clk);
      if (avs_readdata[b] === 1'b0) begin
        got = cyc - start;
        break;
      end
    end
    avs_read = 1'b0;
    check(name, got, exp_lat);
  endtask

  typedef struct {
    logic        do_wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   c0, r0;
  logic [31:0] d;

  initial begin
    tbl.push_back('{1'b0, 2'd0, 32'h0,         32'hF, "rst_data"});
    tbl.push_back('{1'b0, 2'd1, 32'h0,         32'h0, "rst_mask"});
    tbl.push_back('{1'b0, 2'd2, 32'h0,         32'h0, "rst_edgecap"});
    tbl.push_back('{1'b0, 2'd3, 32'h0,         32'h1, "rst_mode"});
    tbl.push_back('{1'b1, 2'd1, 32'hFFFF_FFF5, 32'h5, "mask_write_trunc"});
    tbl.push_back('{1'b1, 2'd0, 32'h0,         32'hF, "data_read_only"});
    tbl.push_back('{1'b1, 2'd3, 32'hFFFF_FFFE, 32'h2, "mode_write_trunc"});
    tbl.push_back('{1'b1, 2'd2, 32'hF,         32'h0, "w1c_on_empty"});
    tbl.push_back('{1'b1, 2'd1, 32'h0,         32'h0, "mask_clear"});
    tbl.push_back('{1'b1, 2'd3, 32'h1,         32'h1, "mode_restore"});

    // 1: reset values and register access table
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    foreach (tbl[i]) begin
      if (tbl[i].do_wr) bus_write(tbl[i].addr, tbl[i].wdata);
      read_check(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // Same-address read and write in one cycle returns the old value
    bus_write(2'd1, 32'h3);
    avs_address = 2'd1; avs_writedata = 32'hC; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0; avs_write = 1'b0;
    check("rw_same_addr_old", avs_readdata, 32'h3);
    read_check("rw_same_addr_new", 2'd1, 32'hC);

    // 2: clean falling step, latency and mode-dependent capture
    do_reset();
    gpio_in[0] = 1'b0; c0 = cyc;
    wait_data_low(0, c0, 11, "fall_latency");
    read_check("mode_rise_ignores_fall", 2'd2, 32'h0);
    bus_write(2'd3, 32'h0);
    gpio_in[0] = 1'b1;
    tick(15);
    read_check("mode_off_ignores_rise", 2'd2, 32'h0);
    bus_write(2'd3, 32'h2);
    gpio_in[0] = 1'b0;
    avs_address = 2'd2; avs_read = 1'b1;
    tick(11);
    check("fall_capture_not_yet", avs_readdata, 32'h0);
    tick(1);
    check("fall_capture_set", avs_readdata, 32'h1);
    avs_read = 1'b0;
    gpio_in = 4'hF;
    tick(12);

    // 3: glitchy input never settles
    do_reset();
    bus_write(2'd3, 32'h3);
    for (int i = 0; i < 10; i++) begin
      gpio_in[2] = 1'b0; tick(5);
      gpio_in[2] = 1'b1; tick(1);
    end
    tick(12);
    read_check("glitch_data", 2'd0, 32'hF);
    read_check("glitch_edgecap", 2'd0 + 2'd2, 32'h0);

    // 4: interrupt assert, clear and re-assert
    do_reset();
    bus_write(2'd3, 32'h3);
    bus_write(2'd1, 32'h2);
    gpio_in[1] = 1'b0;
    tick(20);
    read_check("irq_edgecap_fall", 2'd2, 32'h2);
    check("irq_after_fall", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'h2);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    gpio_in[1] = 1'b1;
    tick(12);
    check("irq_after_rise", {31'd0, irq}, 32'd1);
    read_check("irq_edgecap_rise", 2'd2, 32'h2);
    bus_write(2'd1, 32'h0);
    check("irq_after_mask_clear", {31'd0, irq}, 32'd0);

    // 5: clear colliding with a capture on the same edge
    do_reset();
    bus_write(2'd3, 32'h3);
    gpio_in[3] = 1'b0;
    tick(10);
    bus_write(2'd2, 32'h8);
    read_check("set_beats_w1c", 2'd2, 32'h8);
    bus_write(2'd2, 32'h8);
    read_check("w1c_clears", 2'd2, 32'h0);
    gpio_in = 4'hF;
    tick(14);

    // 6: reset in the middle of a debounce count
    do_reset();
    bus_write(2'd3, 32'h2);
    bus_write(2'd1, 32'h1);
    gpio_in[0] = 1'b0;
    tick(7);
    reset_reset_n = 1'b0; avs_address = 2'd0; avs_read = 1'b1;
    @(negedge clk_clk);
    reset_reset_n = 1'b1; avs_read = 1'b0;
    r0 = cyc;
    check("reset_mid_read", avs_readdata, 32'h0);
    wait_data_low(0, r0, 11, "recount_after_reset");
    read_check("reset_mask", 2'd1, 32'h0);
    read_check("reset_edgecap", 2'd2, 32'h0);
    read_check("reset_mode", 2'd3, 32'h1);
    gpio_in = 4'hF;
    tick(14);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      avs_read      = ($urandom_range(0, 2) == 0);
      avs_write     = ($urandom_range(0, 5) == 0);
      avs_address   = 2'($urandom_range(0, 3));
      avs_writedata = $urandom;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 15) == 0) gpio_in[b] = ~gpio_in[b];
      reset_reset_n = ($urandom_range(0, 999) != 0);
      @(negedge clk_clk);
    end
    avs_read = 1'b0; avs_write = 1'b0; reset_reset_n = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
